data_memory_multicycle: RTL and testbench

DATA_MEMORY_MULTICYCLE -- requirements
Module: data_memory_multicycle

---
 rtl/data_memory_multicycle.sv | 82 ++++++++
 tb/tb_data_memory_multicycle.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_memory_multicycle.sv
// data_memory_multicycle: word-addressed data RAM with fixed multi-cycle access latency and pipeline stall handshake
// Ports: clk/reset (sync, active-high); wr_en/rd_en/addr/wr_data request from MEM stage;
//        rd_data registered load result; ready lets MEM advance; done pulses on completion;
//        stall_cycles saturating count of cycles with ready low.
module data_memory_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 16384,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           stall_cycles
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [AW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [31:0]           r_stall;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic                  w_req;
  logic                  w_last;
  logic                  w_unused;
  assign w_req        = rd_en | wr_en;
  assign w_last       = (r_state == BUSY) && (r_cnt == 4'd0);
  assign ready        = (r_state == DONE) || ((r_state == IDLE) && !w_req);
  assign done         = r_done;
  assign rd_data      = r_rdata;
  assign stall_cycles = r_stall;
  // Byte offset and bits above the RAM index are deliberately dropped so addresses wrap.
  assign w_unused     = &{1'b0, addr[ADDR_WIDTH-1:AW+2], addr[1:0]};
  // Array is never cleared; a reset landing on the final BUSY edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && w_last && r_we) r_mem[r_idx] <= r_wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_stall <= 32'd0;
      r_we    <= 1'b0;
    end else begin
      if (!ready && r_stall != 32'hFFFF_FFFF) r_stall <= r_stall + 32'd1;
      case (r_state)
        IDLE: if (w_req) begin
          r_idx   <= addr[AW+1:2];
          r_wdata <= wr_data;
          r_we    <= wr_en;
          r_cnt   <= CNT_INIT;
          r_state <= BUSY;
        end
        BUSY: if (r_cnt == 4'd0) begin
          if (!r_we) r_rdata <= r_mem[r_idx];
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_multicycle.sv
// tb_data_memory_multicycle: directed and randomized checks of data_memory_multicycle against a transaction-level model
module tb_data_memory_multicycle;
  localparam int L = 4;
  localparam int D = 16384;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        ready;
  logic        done;
  logic [31:0] stall_cycles;
  int n_chk = 0;
  int n_fail = 0;
  bit run = 1'b0;
  int m_busy = 0;
  bit m_done = 1'b0;
  bit m_we = 1'b0;
  bit m_rdk = 1'b1;
  int m_idx = 0;
  logic [31:0] m_rd = 32'd0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_mem [D];
  bit m_known [D];

  data_memory_multicycle #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(D), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ready(ready), .done(done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return m_done || (m_busy == 0 && !rd_en && !wr_en);
  endfunction

  // Model: an accepted request is followed by L busy cycles, then one completion cycle.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_done = 1'b0; m_rd = 32'd0; m_rdk = 1'b1; m_stall = 32'd0;
    end else begin
      if (!exp_ready() && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (m_done) m_done = 1'b0;
      else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          if (m_we) begin m_mem[m_idx] = m_data; m_known[m_idx] = 1'b1; end
          else begin m_rd = m_mem[m_idx]; m_rdk = m_known[m_idx]; end
          m_done = 1'b1;
        end
      end else if (rd_en || wr_en) begin
        m_busy = L; m_we = wr_en; m_idx = int'((addr >> 2) % D); m_data = wr_data;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (run && !reset) begin
      chk("ready", {31'd0, ready}, {31'd0, exp_ready()});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("stall_cycles", stall_cycles, m_stall);
      if (m_rdk) chk("rd_data", rd_data, m_rd);
    end
  end

  task automatic acc(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                     input bit scr, output int low);
    low = 0;
    wr_en = we; rd_en = re; addr = a; wr_data = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready) break;
      low++;
      if (scr && low == 1) begin
        @(posedge clk); #1;
        wr_en = 1'($urandom); rd_en = 1'($urandom); addr = $urandom; wr_data = $urandom;
      end
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
    chk("done_at_ready", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int low;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; run = 1'b1;
    @(negedge clk);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    acc(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, low);
    chk("wr_low_cycles", low, 32'd5);
    chk("wr_stall", stall_cycles, 32'd5);
    acc(1'b0, 1'b1, 32'h10, 32'd0, 1'b0, low);
    chk("rd_low_cycles", low, 32'd5);
    chk("rd_value", rd_data, 32'hDEAD_BEEF);
    chk("rd_stall", stall_cycles, 32'd10);
    acc(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, low);
    chk("both_low_cycles", low, 32'd5);
    chk("both_keeps_rd", rd_data, 32'hDEAD_BEEF);
    acc(1'b0, 1'b1, 32'h20, 32'd0, 1'b0, low);
    chk("rd_after_both", rd_data, 32'h1234_5678);
    wr_en = 1'b1; addr = 32'h10; wr_data = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rd_data", rd_data, 32'd0);
    chk("abort_stall", stall_cycles, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    acc(1'b0, 1'b1, 32'h10, 32'd0, 1'b0, low);
    chk("abort_no_write", rd_data, 32'hDEAD_BEEF);
    acc(1'b1, 1'b0, 32'h24, 32'h5555_AAAA, 1'b0, low);
    acc(1'b0, 1'b1, 32'h10010, 32'd0, 1'b0, low);
    chk("wrap_high", rd_data, 32'hDEAD_BEEF);
    acc(1'b0, 1'b1, 32'h24, 32'd0, 1'b0, low);
    acc(1'b0, 1'b1, 32'h13, 32'd0, 1'b0, low);
    chk("wrap_low", rd_data, 32'hDEAD_BEEF);
    acc(1'b1, 1'b0, 32'h40, 32'hA5A5_0001, 1'b0, low);
    chk("b2b_low1", low, 32'd5);
    acc(1'b1, 1'b0, 32'h44, 32'hA5A5_0002, 1'b0, low);
    chk("b2b_low2", low, 32'd5);
    acc(1'b0, 1'b1, 32'h40, 32'd0, 1'b0, low);
    chk("b2b_low3", low, 32'd5);
    chk("b2b_rd", rd_data, 32'hA5A5_0001);
    for (int i = 0; i < 80; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) << 16) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      acc(op == 1 || op == 2, op != 1, a, $urandom, 1'($urandom_range(0, 1)), low);
      chk("rand_low_cycles", low, 32'd5);
    end
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
